// File: rtl/message_overlay_map.sv
// Multi-message 1-bpp text overlay with frame-synchronous blink/hold FSM and a completion pulse.
// Latency: one pixel clock from offsetX/offsetY/InsideRectangle to RGBout/drawingRequest.
// Backpressure: none; free-running pixel stream, the message selector is only sampled on startOfFrame.
//
// Ports:
//   clk, resetN          pixel clock, synchronous active-low reset
//   startOfFrame         one-cycle pulse per frame; the only cycle the FSM may change state
//   offsetX, offsetY     pixel offset from the overlay rectangle top-left
//   InsideRectangle      pixel lies inside the overlay bracket
//   message              requested message (0 = none, values above MSG_COUNT also mean none)
//   drawingRequest       overlay pixel opaque, aligned with RGBout
//   RGBout               registered RGB332 colour, 8'h00 = transparent
//   messageActive        FSM not idle
//   messageDone          one-cycle pulse when the hold time expires
module message_overlay_map #(
  parameter int          MSG_COUNT    = 3,
  parameter int          SEL_W        = 2,
  parameter int          WIDTH_X      = 70,
  parameter int          HEIGHT_Y     = 12,
  parameter int          SCALE_SHIFT  = 2,
  parameter logic [7:0]  COLOR        = 8'hFF,
  parameter int          BLINK_FRAMES = 30,
  parameter int          HOLD_FRAMES  = 180
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             startOfFrame,
  input  logic [10:0]      offsetX,
  input  logic [10:0]      offsetY,
  input  logic             InsideRectangle,
  input  logic [SEL_W-1:0] message,
  output logic             drawingRequest,
  output logic [7:0]       RGBout,
  output logic             messageActive,
  output logic             messageDone
);

  // Bitmap store: entry 0 is blank so a zero selector never lights a pixel.
  localparam int ROM_N = 4;
  localparam int ROM_H = 12;
  localparam int ROM_W = 70;

  // Row literals are written MSB-first, so the leftmost literal bit is column 0.
  localparam logic [ROM_W-1:0] BORDER_EDGE = {ROM_W{1'b1}};
  localparam logic [ROM_W-1:0] BORDER_MID  = {1'b1, {68{1'b0}}, 1'b1};
  localparam logic [ROM_W-1:0] CHECK_EVEN  = {35{2'b10}};
  localparam logic [ROM_W-1:0] CHECK_ODD   = {35{2'b01}};
  localparam logic [ROM_W-1:0] STRIPES     = {{17{4'b1100}}, 2'b11};

  localparam logic [ROM_W-1:0] ROM [ROM_N][ROM_H] = '{
    '{default: '0},
    '{BORDER_EDGE, BORDER_MID, BORDER_MID, BORDER_MID, BORDER_MID, BORDER_MID,
      BORDER_MID, BORDER_MID, BORDER_MID, BORDER_MID, BORDER_MID, BORDER_EDGE},
    '{CHECK_EVEN, CHECK_ODD, CHECK_EVEN, CHECK_ODD, CHECK_EVEN, CHECK_ODD,
      CHECK_EVEN, CHECK_ODD, CHECK_EVEN, CHECK_ODD, CHECK_EVEN, CHECK_ODD},
    '{default: STRIPES}
  };

  // Visible bitmap window, clipped to what the store actually holds.
  localparam logic [10:0] ROW_LIM = 11'((HEIGHT_Y < ROM_H) ? HEIGHT_Y : ROM_H);
  localparam logic [10:0] COL_LIM = 11'((WIDTH_X  < ROM_W) ? WIDTH_X  : ROM_W);

  // Counters sized for the longer of the two frame timers, at least one bit.
  localparam int MAXF = (BLINK_FRAMES > HOLD_FRAMES) ? BLINK_FRAMES : HOLD_FRAMES;
  localparam int CW   = (MAXF < 2) ? 1 : $clog2(MAXF + 1);
  localparam logic [CW-1:0] BLINK_LAST = CW'((BLINK_FRAMES == 0) ? 0 : BLINK_FRAMES - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'((HOLD_FRAMES  == 0) ? 0 : HOLD_FRAMES  - 1);
  localparam logic [CW-1:0] CNT_MAX    = '1;

  typedef enum logic [1:0] {IDLE, SHOW, DONE} state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] msg_q, msg_d;
  logic [CW-1:0]    frame_cnt_q, frame_cnt_d;
  logic [CW-1:0]    blink_cnt_q, blink_cnt_d;
  logic             visible_q, visible_d;
  logic             done_q, done_d;
  logic [7:0]       rgb_q, rgb_d;

  logic [SEL_W-1:0] msg_eff;
  logic [10:0]      col, row;
  logic [1:0]       rom_sel;
  logic [3:0]       row_idx;
  logic [6:0]       bit_idx;
  logic             in_range;
  logic             rom_bit;

  // Out-of-range selectors collapse to "no message".
  assign msg_eff = (int'(message) > MSG_COUNT) ? '0 : message;

  always_comb begin
    state_d     = state_q;
    msg_d       = msg_q;
    frame_cnt_d = frame_cnt_q;
    blink_cnt_d = blink_cnt_q;
    visible_d   = visible_q;
    done_d      = 1'b0;
    if (startOfFrame) begin
      unique case (state_q)
        IDLE: begin
          if (msg_eff != '0) begin
            state_d     = SHOW;
            msg_d       = msg_eff;
            frame_cnt_d = '0;
            blink_cnt_d = '0;
            visible_d   = 1'b1;
          end
        end
        SHOW: begin
          if (msg_eff == '0) begin
            state_d = IDLE;
          end else if (msg_eff != msg_q) begin
            msg_d       = msg_eff;
            frame_cnt_d = '0;
            blink_cnt_d = '0;
            visible_d   = 1'b1;
          end else begin
            frame_cnt_d = (frame_cnt_q == CNT_MAX) ? frame_cnt_q : frame_cnt_q + CW'(1);
            blink_cnt_d = (blink_cnt_q == CNT_MAX) ? blink_cnt_q : blink_cnt_q + CW'(1);
            if ((BLINK_FRAMES != 0) && (blink_cnt_q == BLINK_LAST)) begin
              blink_cnt_d = '0;
              visible_d   = ~visible_q;
            end
            // Hold expiry overrides a blink toggle landing on the same frame.
            if ((HOLD_FRAMES != 0) && (frame_cnt_q == HOLD_LAST)) begin
              state_d   = DONE;
              visible_d = 1'b1;
              done_d    = 1'b1;
            end
          end
        end
        DONE: begin
          if (msg_eff == '0) begin
            state_d = IDLE;
          end else if (msg_eff != msg_q) begin
            state_d     = SHOW;
            msg_d       = msg_eff;
            frame_cnt_d = '0;
            blink_cnt_d = '0;
            visible_d   = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Pixel path: the store is only indexed when row/col fall inside the bitmap.
  always_comb begin
    col      = offsetX >> SCALE_SHIFT;
    row      = offsetY >> SCALE_SHIFT;
    rom_sel  = 2'(msg_q);
    row_idx  = 4'(row);
    bit_idx  = 7'(ROM_W - 1) - 7'(col);
    in_range = (row < ROW_LIM) && (col < COL_LIM) && (int'(msg_q) < ROM_N);
    rom_bit  = 1'b0;
    if (in_range) begin
      rom_bit = ROM[rom_sel][row_idx][bit_idx];
    end
    rgb_d = 8'h00;
    if ((state_q != IDLE) && visible_q && InsideRectangle && rom_bit) begin
      rgb_d = COLOR;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q     <= IDLE;
      msg_q       <= '0;
      frame_cnt_q <= '0;
      blink_cnt_q <= '0;
      visible_q   <= 1'b1;
      done_q      <= 1'b0;
      rgb_q       <= 8'h00;
    end else begin
      state_q     <= state_d;
      msg_q       <= msg_d;
      frame_cnt_q <= frame_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      visible_q   <= visible_d;
      done_q      <= done_d;
      rgb_q       <= rgb_d;
    end
  end

  assign RGBout         = rgb_q;
  assign drawingRequest = (rgb_q != 8'h00);
  assign messageActive  = (state_q != IDLE);
  assign messageDone    = done_q;

endmodule
